// File: rtl/uncache_axi_bridge.sv
// Single-beat AXI3 master for uncached loads and stores: one transaction in flight,
// completion signalled by a one-cycle reload pulse carrying read data and error status.
module uncache_axi_bridge #(
  parameter logic [3:0] RD_ID = 4'd0,
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  // uncache stage request side
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  input  logic        wr_req,
  input  logic [3:0]  wr_wstrb,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        reload,
  output logic [31:0] rd_data,
  output logic        bus_err,
  // AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AW channel
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  // W channel
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // B channel
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_AR   = 3'd1,
    RD_R    = 3'd2,
    WR_AW_W = 3'd3,
    WR_B    = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [3:0]  strb_q;
  logic [31:0] rd_data_q;
  logic        resp_err_q;
  logic        aw_done_q;
  logic        w_done_q;

  logic        ar_hs;
  logic        r_hs;
  logic        aw_hs;
  logic        w_hs;
  logic        b_hs;

  // IDs are fixed per direction and only single beats are issued, so these carry no information
  logic        unused_inputs;
  assign unused_inputs = ^{rid, rlast, bid};

  assign ar_hs = arvalid & arready;
  assign r_hs  = rvalid & rready;
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign b_hs  = bvalid & bready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (wr_req) begin
          next_state = WR_AW_W;
        end else if (rd_req) begin
          next_state = RD_AR;
        end
      end
      RD_AR: begin
        if (ar_hs) begin
          next_state = RD_R;
        end
      end
      RD_R: begin
        if (r_hs) begin
          next_state = DONE;
        end
      end
      // AW and W may complete in either order or together
      WR_AW_W: begin
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          next_state = WR_B;
        end
      end
      WR_B: begin
        if (b_hs) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    arvalid = (state == RD_AR);
    rready  = (state == RD_R);
    awvalid = (state == WR_AW_W) && !aw_done_q;
    wvalid  = (state == WR_AW_W) && !w_done_q;
    bready  = (state == WR_B);
    reload  = (state == DONE);
    bus_err = (state == DONE) && resp_err_q;
  end

  // Request fields are captured only while IDLE so the bus sees stable values mid-transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      strb_q     <= 4'd0;
      rd_data_q  <= 32'd0;
      resp_err_q <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          if (wr_req) begin
            addr_q <= wr_addr;
            data_q <= wr_data;
            strb_q <= wr_wstrb;
          end else if (rd_req) begin
            addr_q <= rd_addr;
          end
        end
        RD_R: begin
          if (r_hs) begin
            rd_data_q  <= rdata;
            resp_err_q <= (rresp != 2'b00);
          end
        end
        WR_AW_W: begin
          if (aw_hs) begin
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            w_done_q <= 1'b1;
          end
        end
        WR_B: begin
          if (b_hs) begin
            resp_err_q <= (bresp != 2'b00);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign arid    = RD_ID;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  assign awid    = WR_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;

  assign wid     = WR_ID;
  assign wdata   = data_q;
  assign wstrb   = strb_q;
  assign wlast   = 1'b1;

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_uncache_axi_bridge.sv
// Randomised bench for uncache_axi_bridge: a delay-programmable AXI slave plus a
// transaction-level model of latency, data, strobes and error reporting.
module tb_uncache_axi_bridge;
  localparam logic [3:0] RD_ID = 4'd0;
  localparam logic [3:0] WR_ID = 4'd1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_req = 1'b0, wr_req = 1'b0;
  logic [31:0] rd_addr = '0, wr_addr = '0, wr_data = '0;
  logic [3:0] wr_wstrb = '0;
  logic reload, bus_err;
  logic [31:0] rd_data;
  logic [3:0] arid, awid, wid;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, awburst;
  logic arvalid, awvalid, wvalid, wlast, rready, bready;
  logic [3:0] wstrb;
  logic arready = 1'b0, awready = 1'b0, wready = 1'b0, rvalid = 1'b0, bvalid = 1'b0, rlast = 1'b0;
  logic [3:0] rid = '0, bid = '0;
  logic [31:0] rdata = '0;
  logic [1:0] rresp = '0, bresp = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // slave configuration and observation log
  int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [31:0] s_rdata = '0;
  logic [1:0] s_rresp = '0, s_bresp = '0;
  int ar_hs = 0, aw_hs = 0, w_hs = 0, r_hs = 0;
  logic [31:0] log_araddr = '0, log_awaddr = '0, log_wdata = '0;
  logic [3:0] log_arid = '0, log_awid = '0, log_wid = '0, log_wstrb = '0;
  logic log_wlast = 1'b0;
  int aw_hs_cyc = 0, w_hs_cyc = 0, b_first = -1;
  int reload_pulses = 0;
  logic [31:0] exp_rd_data = '0;

  uncache_axi_bridge #(.RD_ID(RD_ID), .WR_ID(WR_ID)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .wr_req(wr_req), .wr_wstrb(wr_wstrb), .wr_addr(wr_addr), .wr_data(wr_data),
    .reload(reload), .rd_data(rd_data), .bus_err(bus_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (reload) reload_pulses++;
  end

  // Slave: decisions made mid-cycle; a handshake seen here completes at the next posedge
  initial begin
    bit r_pend = 0, b_pend = 0, aw_got = 0, w_got = 0;
    int ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
      end else begin
        if (r_pend) begin
          rvalid = (r_c >= r_delay);
          r_c++;
          rdata = rvalid ? s_rdata : $urandom;
          rresp = s_rresp;
          rid = 4'($urandom);
          rlast = 1'($urandom);
          if (rvalid && rready) begin r_hs++; r_pend = 0; end
        end else rvalid = 0;
        if (b_pend) begin
          bvalid = (b_c >= b_delay);
          b_c++;
          bresp = s_bresp;
          bid = 4'($urandom);
          if (bvalid && bready) b_pend = 0;
        end else bvalid = 0;
        if (arvalid) begin
          arready = (ar_c >= ar_delay);
          ar_c++;
          if (arready) begin
            ar_hs++; log_araddr = araddr; log_arid = arid;
            ar_c = 0; r_pend = 1; r_c = 0;
          end
        end else begin arready = 0; ar_c = 0; end
        if (awvalid) begin
          awready = (aw_c >= aw_delay);
          aw_c++;
          if (awready) begin
            aw_hs++; log_awaddr = awaddr; log_awid = awid; aw_hs_cyc = cyc;
            aw_c = 0; aw_got = 1;
          end
        end else begin awready = 0; aw_c = 0; end
        if (wvalid) begin
          wready = (w_c >= w_delay);
          w_c++;
          if (wready) begin
            w_hs++; log_wdata = wdata; log_wstrb = wstrb; log_wid = wid; log_wlast = wlast;
            w_hs_cyc = cyc; w_c = 0; w_got = 1;
          end
        end else begin wready = 0; w_c = 0; end
        if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pend = 1; b_c = 0; end
        if (bready && b_first < 0) b_first = cyc;
      end
    end
  end

  task automatic set_delays(input int ard, input int rd, input int awd, input int wd, input int bd);
    ar_delay = ard; r_delay = rd; aw_delay = awd; w_delay = wd; b_delay = bd;
  endtask

  // Presents one request, holds it until reload and scrambles the inputs once accepted
  task automatic drive_txn(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int maxc, output bit ok, output int lat);
    int start;
    @(negedge clk);
    if (is_wr) begin
      wr_req = 1; wr_addr = addr; wr_data = data; wr_wstrb = strb;
    end else begin
      rd_req = 1; rd_addr = addr;
    end
    start = cyc; ok = 0; lat = -1; b_first = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (i == 0) begin
        rd_addr = $urandom; wr_addr = $urandom; wr_data = $urandom; wr_wstrb = 4'($urandom);
      end
      if (reload) begin ok = 1; lat = cyc - start; break; end
    end
    rd_req = 0; wr_req = 0;
  endtask

  task automatic test_reset();
    rst = 1; rd_req = 0; wr_req = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({arvalid, rready, awvalid, wvalid, bready, reload, bus_err} !== 7'b0) begin
      errors++; $display("[TB] FAIL reset_ctrl: got %b expected 0000000",
                         {arvalid, rready, awvalid, wvalid, bready, reload, bus_err});
    end
    checks++;
    if (rd_data !== 32'd0 || araddr !== 32'd0 || wdata !== 32'd0 || wstrb !== 4'd0) begin
      errors++; $display("[TB] FAIL reset_data: rd_data=%h araddr=%h wdata=%h wstrb=%h expected all 0",
                         rd_data, araddr, wdata, wstrb);
    end
    checks++;
    if ({arlen, awlen, arsize, awsize, arburst, awburst, wlast} !== {8'd0, 8'd0, 3'b010, 3'b010, 2'b01, 2'b01, 1'b1}) begin
      errors++; $display("[TB] FAIL consts: got len %h/%h size %b/%b burst %b/%b wlast %b expected 0/0 010/010 01/01 1",
                         arlen, awlen, arsize, awsize, arburst, awburst, wlast);
    end
    checks++;
    if (arid !== RD_ID || awid !== WR_ID || wid !== WR_ID) begin
      errors++; $display("[TB] FAIL ids: got arid=%h awid=%h wid=%h expected %h %h %h",
                         arid, awid, wid, RD_ID, WR_ID, WR_ID);
    end
    rst = 0;
    exp_rd_data = 32'd0;
  endtask

  task automatic test_read_basic();
    bit ok; int lat; int base_ar;
    set_delays(0, 0, 0, 0, 0);
    s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b00;
    base_ar = ar_hs;
    drive_txn(0, 32'h1FAF_FFF0, 32'd0, 4'd0, 20, ok, lat);
    checks++;
    if (!ok || lat != 3) begin errors++; $display("[TB] FAIL read_latency: got ok=%0d lat=%0d expected 3", ok, lat); end
    checks++;
    if (rd_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL read_data: got %h expected deadbeef", rd_data); end
    checks++;
    if (bus_err !== 1'b0) begin errors++; $display("[TB] FAIL read_err: got %b expected 0", bus_err); end
    checks++;
    if (log_araddr !== 32'h1FAF_FFF0 || log_arid !== RD_ID || ar_hs != base_ar + 1) begin
      errors++; $display("[TB] FAIL read_ar: got addr=%h id=%h hs=%0d expected 1faffff0 %h %0d",
                         log_araddr, log_arid, ar_hs - base_ar, RD_ID, 1);
    end
    exp_rd_data = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (reload !== 1'b0 || bus_err !== 1'b0) begin
      errors++; $display("[TB] FAIL reload_width: got reload=%b bus_err=%b expected 0 0", reload, bus_err);
    end
  endtask

  task automatic test_write_w_first();
    bit ok; int lat; int base_pulses, base_aw, base_w;
    set_delays(0, 0, 2, 0, 0);
    s_bresp = 2'b00;
    base_pulses = reload_pulses; base_aw = aw_hs; base_w = w_hs;
    drive_txn(1, 32'hBFD0_0000, 32'h1234_5678, 4'b0011, 30, ok, lat);
    checks++;
    if (!ok || lat != 5) begin errors++; $display("[TB] FAIL write_latency: got ok=%0d lat=%0d expected 5", ok, lat); end
    checks++;
    if (aw_hs_cyc - w_hs_cyc != 2) begin
      errors++; $display("[TB] FAIL w_before_aw: got aw-w gap %0d expected 2", aw_hs_cyc - w_hs_cyc);
    end
    checks++;
    if (b_first != aw_hs_cyc + 1) begin
      errors++; $display("[TB] FAIL bready_timing: got cycle %0d expected %0d", b_first, aw_hs_cyc + 1);
    end
    checks++;
    if (log_awaddr !== 32'hBFD0_0000 || log_wdata !== 32'h1234_5678 || log_wstrb !== 4'b0011) begin
      errors++; $display("[TB] FAIL write_fields: got %h %h %b expected bfd00000 12345678 0011",
                         log_awaddr, log_wdata, log_wstrb);
    end
    checks++;
    if (log_awid !== WR_ID || log_wid !== WR_ID || log_wlast !== 1'b1) begin
      errors++; $display("[TB] FAIL write_ids: got awid=%h wid=%h wlast=%b expected %h %h 1",
                         log_awid, log_wid, log_wlast, WR_ID, WR_ID);
    end
    checks++;
    if (rd_data !== exp_rd_data || bus_err !== 1'b0) begin
      errors++; $display("[TB] FAIL write_keeps_rd: got rd_data=%h bus_err=%b expected %h 0", rd_data, bus_err, exp_rd_data);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (reload_pulses != base_pulses + 1 || aw_hs != base_aw + 1 || w_hs != base_w + 1) begin
      errors++; $display("[TB] FAIL write_counts: got reload=%0d aw=%0d w=%0d expected 1 1 1",
                         reload_pulses - base_pulses, aw_hs - base_aw, w_hs - base_w);
    end
  endtask

  task automatic test_priority();
    int base_ar, base_aw, start, t1; bit got1, got2;
    set_delays(0, 0, 0, 0, 0);
    s_rdata = 32'hA5A5_0F0F; s_rresp = 2'b00; s_bresp = 2'b00;
    base_ar = ar_hs; base_aw = aw_hs; got1 = 0; got2 = 0; t1 = 0;
    @(negedge clk);
    wr_req = 1; wr_addr = 32'h0000_1000; wr_data = 32'hCAFE_F00D; wr_wstrb = 4'hF;
    rd_req = 1; rd_addr = 32'h0000_2000;
    start = cyc;
    for (int i = 0; i < 20 && !got1; i++) begin
      @(negedge clk);
      if (reload) begin got1 = 1; t1 = cyc; end
    end
    wr_req = 0;
    checks++;
    if (!got1 || t1 - start != 3 || aw_hs != base_aw + 1 || ar_hs != base_ar) begin
      errors++; $display("[TB] FAIL priority_write_first: got ok=%0d lat=%0d aw=%0d ar=%0d expected 1 3 1 0",
                         got1, t1 - start, aw_hs - base_aw, ar_hs - base_ar);
    end
    for (int i = 0; i < 20 && !got2; i++) begin
      @(negedge clk);
      if (reload) begin
        got2 = 1;
        checks++;
        if (cyc - t1 != 4 || ar_hs != base_ar + 1 || log_araddr !== 32'h0000_2000 || rd_data !== 32'hA5A5_0F0F) begin
          errors++; $display("[TB] FAIL priority_read_after: got gap=%0d ar=%0d addr=%h data=%h expected 4 1 00002000 a5a50f0f",
                             cyc - t1, ar_hs - base_ar, log_araddr, rd_data);
        end
      end
    end
    rd_req = 0;
    checks++;
    if (!got2) begin errors++; $display("[TB] FAIL priority_read_timeout: got no reload expected one"); end
    exp_rd_data = 32'hA5A5_0F0F;
  endtask

  task automatic test_back_to_back();
    int base_aw, base_pulses, t1, t2; bit got1, got2;
    set_delays(0, 0, 0, 0, 0);
    s_bresp = 2'b00;
    base_aw = aw_hs; base_pulses = reload_pulses; got1 = 0; got2 = 0; t1 = 0; t2 = 0;
    @(negedge clk);
    wr_req = 1; wr_addr = 32'h0000_0040; wr_data = 32'h1111_1111; wr_wstrb = 4'h1;
    for (int i = 0; i < 40 && !got2; i++) begin
      @(negedge clk);
      if (reload) begin
        if (!got1) begin
          got1 = 1; t1 = cyc;
          wr_addr = 32'h0000_0044; wr_data = 32'h2222_2222; wr_wstrb = 4'h8;
        end else begin
          got2 = 1; t2 = cyc;
        end
      end
    end
    wr_req = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (!got2 || t2 - t1 != 4) begin errors++; $display("[TB] FAIL b2b_gap: got ok=%0d gap=%0d expected 4", got2, t2 - t1); end
    checks++;
    if (aw_hs != base_aw + 2 || reload_pulses != base_pulses + 2) begin
      errors++; $display("[TB] FAIL b2b_counts: got aw=%0d reload=%0d expected 2 2", aw_hs - base_aw, reload_pulses - base_pulses);
    end
    checks++;
    if (log_awaddr !== 32'h0000_0044 || log_wdata !== 32'h2222_2222 || log_wstrb !== 4'h8) begin
      errors++; $display("[TB] FAIL b2b_second: got %h %h %h expected 00000044 22222222 8", log_awaddr, log_wdata, log_wstrb);
    end
  endtask

  task automatic test_bus_err();
    bit ok; int lat;
    set_delays(0, 0, 0, 0, 0);
    s_rdata = 32'h0BAD_0BAD; s_rresp = 2'b10;
    drive_txn(0, 32'h0000_0100, 32'd0, 4'd0, 20, ok, lat);
    checks++;
    if (!ok || bus_err !== 1'b1 || rd_data !== 32'h0BAD_0BAD) begin
      errors++; $display("[TB] FAIL rresp_err: got ok=%0d bus_err=%b data=%h expected 1 1 0bad0bad", ok, bus_err, rd_data);
    end
    exp_rd_data = 32'h0BAD_0BAD;
    s_rdata = 32'h600D_600D; s_rresp = 2'b00;
    drive_txn(0, 32'h0000_0104, 32'd0, 4'd0, 20, ok, lat);
    checks++;
    if (!ok || bus_err !== 1'b0 || rd_data !== 32'h600D_600D) begin
      errors++; $display("[TB] FAIL rresp_ok: got ok=%0d bus_err=%b data=%h expected 1 0 600d600d", ok, bus_err, rd_data);
    end
    exp_rd_data = 32'h600D_600D;
    s_bresp = 2'b11;
    drive_txn(1, 32'h0000_0200, 32'h5555_AAAA, 4'hF, 20, ok, lat);
    checks++;
    if (!ok || bus_err !== 1'b1 || rd_data !== exp_rd_data) begin
      errors++; $display("[TB] FAIL bresp_err: got ok=%0d bus_err=%b data=%h expected 1 1 %h", ok, bus_err, rd_data, exp_rd_data);
    end
    s_bresp = 2'b00;
  endtask

  task automatic test_reset_mid();
    bit ok; int lat; int base_ar, base_pulses; bit seen;
    set_delays(0, 20, 0, 0, 0);
    s_rdata = 32'h7777_7777; s_rresp = 2'b00;
    base_ar = ar_hs; seen = 0;
    @(negedge clk);
    rd_req = 1; rd_addr = 32'h0000_0300;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (ar_hs != base_ar) seen = 1;
    end
    @(negedge clk);
    base_pulses = reload_pulses;
    rst = 1;
    @(negedge clk);
    rd_req = 0;
    checks++;
    if (!seen || {arvalid, rready, awvalid, wvalid, bready, reload} !== 6'b0) begin
      errors++; $display("[TB] FAIL mid_reset_outputs: got ar_seen=%0d ctrl=%b expected 1 000000",
                         seen, {arvalid, rready, awvalid, wvalid, bready, reload});
    end
    @(negedge clk);
    rst = 0;
    exp_rd_data = 32'd0;
    repeat (25) @(negedge clk);
    checks++;
    if (reload_pulses != base_pulses || rd_data !== 32'd0) begin
      errors++; $display("[TB] FAIL mid_reset_abandon: got reloads=%0d rd_data=%h expected 0 00000000",
                         reload_pulses - base_pulses, rd_data);
    end
    set_delays(0, 0, 0, 0, 0);
    s_rdata = 32'h8888_1234;
    drive_txn(0, 32'h0000_0304, 32'd0, 4'd0, 20, ok, lat);
    checks++;
    if (!ok || lat != 3 || rd_data !== 32'h8888_1234 || log_araddr !== 32'h0000_0304) begin
      errors++; $display("[TB] FAIL post_reset_read: got ok=%0d lat=%0d data=%h addr=%h expected 1 3 88881234 00000304",
                         ok, lat, rd_data, log_araddr);
    end
    exp_rd_data = 32'h8888_1234;
  endtask

  task automatic test_random();
    bit ok, is_wr; int lat, exp_lat, base_pulses, n;
    logic [31:0] addr, data; logic [3:0] strb; logic [1:0] resp; logic exp_err;
    int ard, rd, awd, wd, bd;
    n = 40;
    base_pulses = reload_pulses;
    for (int t = 0; t < n; t++) begin
      is_wr = 1'($urandom);
      addr = $urandom; data = $urandom; strb = 4'($urandom);
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ard = $urandom_range(0, 3); rd = $urandom_range(0, 3);
      awd = $urandom_range(0, 3); wd = $urandom_range(0, 3); bd = $urandom_range(0, 3);
      set_delays(ard, rd, awd, wd, bd);
      s_rdata = $urandom; s_rresp = resp; s_bresp = resp;
      exp_err = (resp != 2'b00);
      if (is_wr) exp_lat = 3 + ((awd > wd) ? awd : wd) + bd;
      else begin exp_lat = 3 + ard + rd; exp_rd_data = s_rdata; end
      drive_txn(is_wr, addr, data, strb, 40, ok, lat);
      checks++;
      if (!ok || lat != exp_lat || bus_err !== exp_err || rd_data !== exp_rd_data) begin
        errors++; $display("[TB] FAIL rand_%0d_%s: got ok=%0d lat=%0d err=%b data=%h expected lat=%0d err=%b data=%h",
                           t, is_wr ? "wr" : "rd", ok, lat, bus_err, rd_data, exp_lat, exp_err, exp_rd_data);
      end
      checks++;
      if (is_wr ? (log_awaddr !== addr || log_wdata !== data || log_wstrb !== strb) : (log_araddr !== addr)) begin
        errors++; $display("[TB] FAIL rand_%0d_fields: got aw=%h wd=%h ws=%h ar=%h expected addr=%h data=%h strb=%h",
                           t, log_awaddr, log_wdata, log_wstrb, log_araddr, addr, data, strb);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (reload_pulses != base_pulses + n) begin
      errors++; $display("[TB] FAIL rand_reload_count: got %0d expected %0d", reload_pulses - base_pulses, n);
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_w_first();
    test_priority();
    test_back_to_back();
    test_bus_err();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
